// File: rtl/frac_div.sv
// Phase-accumulator fractional clock divider: clkout is the accumulator MSB.
// The divisor is shadowed in div_act and only reloaded on a wrap (or while idle) to avoid runt pulses.
module frac_div #(
    parameter int ACC_W = 32
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic [ACC_W-1:0] div,
    output logic             clkout,
    output logic             tick,
    output logic [ACC_W-1:0] phase,
    output logic             valid
);

    localparam logic [ACC_W-1:0] DIV_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] div_act_q, div_act_d;
    logic [ACC_W-1:0] div_clamped;
    logic             tick_q, tick_d;
    logic             valid_q, valid_d;
    logic             carry;

    always_comb begin
        {carry, acc_d} = {1'b0, acc_q} + {1'b0, div_act_q};
        div_clamped    = (div > DIV_MAX) ? DIV_MAX : div;
        // Reload only at a wrap boundary so a new divisor always starts a whole period.
        div_act_d = div_act_q;
        if (div_act_q == '0 || carry) begin
            div_act_d = div_clamped;
        end
        tick_d  = ~acc_q[ACC_W-1] & acc_d[ACC_W-1];
        valid_d = valid_q | carry;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            div_act_q <= '0;
            tick_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            div_act_q <= div_act_d;
            tick_q    <= tick_d;
            valid_q   <= valid_d;
        end
    end

    assign clkout = acc_q[ACC_W-1];
    assign tick   = tick_q;
    assign phase  = acc_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_frac_div.sv
// Directed self-checking bench for frac_div (ACC_W = 32); outputs sampled on the falling edge.
module tb_frac_div;

    logic        clkin;
    logic        reset_n;
    logic [31:0] div;
    logic        clkout;
    logic        tick;
    logic [31:0] phase;
    logic        valid;

    int checks = 0;
    int errors = 0;

    frac_div #(.ACC_W(32)) dut (
        .clkin  (clkin),
        .reset_n(reset_n),
        .div    (div),
        .clkout (clkout),
        .tick   (tick),
        .phase  (phase),
        .valid  (valid)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    // Hold reset for two cycles with div already applied, release on a falling edge.
    task automatic do_reset(input logic [31:0] d);
        reset_n = 1'b0;
        div     = d;
        @(negedge clkin);
        @(negedge clkin);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        div     = 32'h4000_0000;
        repeat (3) @(negedge clkin);
        checks++;
        if ({clkout, tick, valid, phase} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state got clk=%b tick=%b valid=%b phase=%h expected all zero",
                     clkout, tick, valid, phase);
        end
    endtask

    task automatic test_quarter();
        logic [31:0] exp_phase [10];
        logic        exp_clk   [10];
        logic        exp_tick  [10];
        logic        exp_valid [10];
        exp_phase = '{32'h0, 32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000,
                      32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
        exp_clk   = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};
        exp_tick  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
        exp_valid = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        do_reset(32'h4000_0000);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clkin);
            checks++;
            if (phase !== exp_phase[k] || clkout !== exp_clk[k] ||
                tick !== exp_tick[k] || valid !== exp_valid[k]) begin
                errors++;
                $display("FAIL quarter_cycle%0d got phase=%h clk=%b tick=%b valid=%b expected phase=%h clk=%b tick=%b valid=%b",
                         k, phase, clkout, tick, valid, exp_phase[k], exp_clk[k], exp_tick[k], exp_valid[k]);
            end
        end
    endtask

    task automatic test_half(input logic [31:0] d);
        do_reset(d);
        @(negedge clkin);
        for (int k = 2; k < 12; k++) begin
            @(negedge clkin);
            checks++;
            if (clkout !== logic'(k % 2 == 0) || phase !== (k % 2 == 0 ? 32'h8000_0000 : 32'h0)) begin
                errors++;
                $display("FAIL half_rate div=%h cycle%0d got clk=%b phase=%h expected clk=%b",
                         d, k, clkout, phase, logic'(k % 2 == 0));
            end
        end
    endtask

    task automatic test_zero_div();
        int  highs = 0;
        bit  rose  = 0;
        do_reset(32'h0);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clkin);
            if (clkout || tick || valid || phase != 0) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL zero_div_frozen got %0d active cycles expected 0", highs);
        end
        div = 32'h4000_0000;
        for (int k = 0; k < 4 && !rose; k++) begin
            @(negedge clkin);
            if (clkout) rose = 1;
        end
        checks++;
        if (!rose) begin
            errors++;
            $display("FAIL zero_div_restart got no clkout rise within 4 cycles expected rise");
        end
    endtask

    task automatic test_count(input logic [31:0] d, input int n, input int exp_edges);
        int   ticks   = 0;
        int   bad     = 0;
        logic prev    = 1'b0;
        do_reset(d);
        for (int k = 0; k < n; k++) begin
            @(negedge clkin);
            if (tick) ticks++;
            if (tick !== (clkout & ~prev)) bad++;
            prev = clkout;
        end
        checks++;
        if (ticks < exp_edges - 1 || ticks > exp_edges + 1) begin
            errors++;
            $display("FAIL edge_count div=%0d got %0d expected %0d +/-1", d, ticks, exp_edges);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tick_align div=%0d got %0d misaligned ticks expected 0", d, bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_phase [10];
        exp_phase = '{32'h8000_0000, 32'hA000_0000, 32'hC000_0000, 32'hE000_0000, 32'h0,
                      32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0, 32'h4000_0000};
        do_reset(32'h2000_0000);
        repeat (4) @(negedge clkin);
        checks++;
        if (phase !== 32'h6000_0000) begin
            errors++;
            $display("FAIL change_pre got phase=%h expected 60000000", phase);
        end
        div = 32'h4000_0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clkin);
            checks++;
            if (phase !== exp_phase[k] || clkout !== exp_phase[k][31]) begin
                errors++;
                $display("FAIL change_step%0d got phase=%h clk=%b expected phase=%h",
                         k, phase, clkout, exp_phase[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        do_reset(32'h4000_0000);
        repeat (6) @(negedge clkin);
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clkin);
            if (tick && clkout && valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL async_setup got no tick with valid within 8 cycles expected one");
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({clkout, tick, valid, phase} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset got clk=%b tick=%b valid=%b phase=%h expected all zero",
                     clkout, tick, valid, phase);
        end
        @(negedge clkin);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        div     = '0;
        test_reset();
        test_quarter();
        test_half(32'h8000_0000);
        test_half(32'hFFFF_FFFF);
        test_zero_div();
        test_count(32'd922441723, 10000, 2147);
        test_count(32'd914027882, 10000, 2128);
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
